// File: rtl/rr_arbiter8.sv
// Registered 8-way round-robin arbiter; the owner keeps the grant until it releases or withdraws.
// Optional hold-time limit with forced revoke: define ARB_TIMEOUT_EN.
module rr_arbiter8 (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic [7:0] iReq,
  input  logic       iRelease,
  output logic [7:0] oGrant,
  output logic [2:0] oGrantIdx,
  output logic       oValid,
  output logic       oTimeout
);

  localparam int N    = 8;
  localparam int IDXW = 3;

  typedef enum logic {IDLE, GRANT} arbStateT;

  arbStateT          stateReg, stateNext;
  logic [IDXW-1:0]   ptrReg, ptrNext;
  logic [IDXW-1:0]   idxReg, idxNext;
  logic [N-1:0]      grantReg, grantNext;
  logic              timeoutReg, timeoutNext;

  logic [N-1:0]      rotReq;
  logic              pickValid;
  logic [IDXW-1:0]   pickOff;
  logic [IDXW-1:0]   pickIdx;
  logic              ownerDone;
  logic              holdExpired;

  // rotReq[k] is the requester k positions after the pointer, so bit 0 has top priority.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : gRotate
      assign rotReq[gi] = iReq[ptrReg + IDXW'(gi)];
    end
  endgenerate

  always_comb begin
    pickValid = 1'b0;
    pickOff   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotReq[i]) begin
        pickValid = 1'b1;
        pickOff   = IDXW'(i);
      end
    end
  end

  assign pickIdx   = ptrReg + pickOff;
  assign ownerDone = iRelease || !iReq[idxReg];

`ifdef ARB_TIMEOUT_EN
  localparam int MAX_HOLD = 16;
  localparam int HOLDW    = $clog2(MAX_HOLD);
  localparam logic [HOLDW-1:0] HOLD_LIMIT = HOLDW'(MAX_HOLD - 1);

  logic [HOLDW-1:0] holdReg, holdNext;

  assign holdExpired = (stateReg == GRANT) && (holdReg == HOLD_LIMIT);

  always_comb begin
    holdNext = '0;
    if (stateReg == GRANT && !ownerDone && !holdExpired) begin
      holdNext = holdReg + 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      holdReg <= '0;
    end else begin
      holdReg <= holdNext;
    end
  end
`else
  assign holdExpired = 1'b0;
`endif

  always_comb begin
    stateNext   = stateReg;
    ptrNext     = ptrReg;
    idxNext     = idxReg;
    grantNext   = grantReg;
    timeoutNext = 1'b0;
    unique case (stateReg)
      IDLE: begin
        if (pickValid) begin
          stateNext = GRANT;
          idxNext   = pickIdx;
          grantNext = N'(1) << pickIdx;
        end
      end
      GRANT: begin
        // A release in the same cycle as expiry counts as a normal exit.
        if (ownerDone || holdExpired) begin
          stateNext   = IDLE;
          grantNext   = '0;
          ptrNext     = idxReg + 1'b1;
          timeoutNext = holdExpired && !ownerDone;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      stateReg   <= IDLE;
      ptrReg     <= '0;
      idxReg     <= '0;
      grantReg   <= '0;
      timeoutReg <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      ptrReg     <= ptrNext;
      idxReg     <= idxNext;
      grantReg   <= grantNext;
      timeoutReg <= timeoutNext;
    end
  end

  assign oGrant    = grantReg;
  assign oGrantIdx = idxReg;
  assign oValid    = (stateReg == GRANT);
  assign oTimeout  = timeoutReg;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Randomized bench for rr_arbiter8 against a behavioural round-robin model.
// Honors ARB_TIMEOUT_EN the same way the design does.
module tb_rr_arbiter8;

`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rstN;
  logic [7:0] iReq;
  logic       iRelease;
  logic [7:0] oGrant;
  logic [2:0] oGrantIdx;
  logic       oValid;
  logic       oTimeout;

  int errCount   = 0;
  int checkCount = 0;

  // Reference model state
  bit mBusy;
  int mOwner;
  int mPtr;
  int mHold;
  bit mTimeout;

  always #5 clk = ~clk;

  rr_arbiter8 dut (
    .iClk      (clk),
    .iRst_n    (rstN),
    .iReq      (iReq),
    .iRelease  (iRelease),
    .oGrant    (oGrant),
    .oGrantIdx (oGrantIdx),
    .oValid    (oValid),
    .oTimeout  (oTimeout)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mBusy = 0; mOwner = 0; mPtr = 0; mHold = 0; mTimeout = 0;
  endtask

  // One clock edge of the arbiter, from the behavioural rules.
  task automatic modelEdge();
    bit doneOwner, expired, found;
    if (mBusy) begin
      doneOwner = iRelease || !iReq[mOwner];
      expired   = TMO_EN && (mHold >= MAX_HOLD - 1);
      if (doneOwner || expired) begin
        mBusy    = 0;
        mPtr     = (mOwner + 1) % 8;
        mHold    = 0;
        mTimeout = expired && !doneOwner;
      end else begin
        mHold    = (mHold + 1 > MAX_HOLD - 1) ? MAX_HOLD - 1 : mHold + 1;
        mTimeout = 0;
      end
    end else begin
      mTimeout = 0;
      found    = 0;
      for (int i = 0; i < 8; i++) begin
        if (!found && iReq[(mPtr + i) % 8]) begin
          found  = 1;
          mOwner = (mPtr + i) % 8;
        end
      end
      if (found) begin
        mBusy = 1;
        mHold = 0;
      end
    end
  endtask

  task automatic checkOutputs();
    checkVal("valid", {31'd0, oValid}, {31'd0, mBusy});
    checkVal("grant", {24'd0, oGrant}, mBusy ? (32'd1 << mOwner) : 32'd0);
    if (mBusy) checkVal("grantIdx", {29'd0, oGrantIdx}, mOwner);
    checkVal("timeout", {31'd0, oTimeout}, {31'd0, mTimeout});
  endtask

  // Returns at a falling edge, ready for new inputs.
  task automatic cycle();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutputs();
    $display("cyc t=%0t req=%02h rel=%0b grant=%02h idx=%0d valid=%0b tmo=%0b",
             $time, iReq, iRelease, oGrant, oGrantIdx, oValid, oTimeout);
  endtask

  initial begin
    rstN = 1'b0; iReq = 8'hFF; iRelease = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkVal("rstGrant", {24'd0, oGrant}, 32'd0);
    checkVal("rstIdx", {29'd0, oGrantIdx}, 32'd0);
    checkVal("rstValid", {31'd0, oValid}, 32'd0);
    checkVal("rstTimeout", {31'd0, oTimeout}, 32'd0);
    rstN = 1'b1;

    // All requesting with frequent releases: rotation 0..7 with idle gaps.
    for (int n = 0; n < 60; n++) begin
      cycle();
      iRelease = ($urandom_range(0, 1) == 0);
    end

    // Mixed random traffic; requests change occasionally so grants persist.
    for (int n = 0; n < 500; n++) begin
      cycle();
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: iReq = 8'h01 << $urandom_range(0, 7);
          1: iReq = 8'hFF;
          2: iReq = 8'h00;
          default: iReq = 8'($urandom);
        endcase
      end
      iRelease = ($urandom_range(0, 5) == 0);
    end

    // Long hold by a single requester: exercises the hold limit when enabled.
    iReq = 8'h20; iRelease = 1'b0;
    for (int n = 0; n < 45; n++) cycle();
    // Release landing on the expiry cycle must count as a normal release.
    for (int n = 0; n < 60; n++) begin
      cycle();
      iRelease = ($urandom_range(0, 15) == 0);
    end

    // Asynchronous reset between edges while a grant is held.
    iReq = 8'h10; iRelease = 1'b0;
    for (int n = 0; n < 20 && !oValid; n++) cycle();
    if (!oValid) checkVal("waitValid", 32'd0, 32'd1);
    #2 rstN = 1'b0;
    #1;
    checkVal("asyncGrant", {24'd0, oGrant}, 32'd0);
    checkVal("asyncValid", {31'd0, oValid}, 32'd0);
    checkVal("asyncIdx", {29'd0, oGrantIdx}, 32'd0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    iReq = 8'hFF;
    cycle();
    for (int n = 0; n < 10; n++) begin
      cycle();
      iRelease = ($urandom_range(0, 1) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
